// File: rtl/encoder83_evt.sv
// ---------------------------------------------------------------------------
// encoder83_evt
//
// Captures rising edges on eight event request lines, keeps them in a
// pending set, and delivers them one at a time as 3-bit codes over a
// valid/ready handshake. The highest set index is always delivered first.
//
// Ports
//   sys_clk    in   1  clock, all state changes on the rising edge
//   sys_rst    in   1  synchronous active-high reset
//   in         in   8  raw event request lines, bit i maps to code i
//   out        out  3  registered event code being offered
//   out_valid  out  1  out holds an undelivered event code
//   out_ready  in   1  consumer accepts out when high together with out_valid
//   pending    out  8  captured events not yet delivered
//   overflow   out  1  sticky: a rise arrived on an already-pending bit
// ---------------------------------------------------------------------------
module encoder83_evt (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic       overflow
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0] state;
    logic [7:0] in_d;
    logic [7:0] rise;
    logic [7:0] rise_q;
    logic [7:0] clr;
    logic [7:0] pending_nxt;
    logic       accept;
    logic [2:0] prio_code;

    // Edge detect is registered once: a rise seen at one edge reaches
    // pending at the following edge, giving a two-edge path from the
    // sampled input to out_valid.
    always_comb begin
        rise = in & ~in_d;
    end

    // NOTE: every combinational output is given a default before any
    // conditional assignment so no path leaves it unassigned (no latch).
    always_comb begin
        accept = 1'b0;
        clr    = 8'h00;
        if (state == PRESENT && out_valid && out_ready) begin
            accept = 1'b1;
            clr    = 8'h01 << out;
        end
        // A rise landing on the bit being cleared keeps it set.
        pending_nxt = (pending & ~clr) | rise_q;
    end

    // Ascending scan, so the last (highest) set bit wins.
    always_comb begin
        prio_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                prio_code = 3'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            in_d      <= 8'h00;
            rise_q    <= 8'h00;
            pending   <= 8'h00;
            out       <= 3'b000;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            state     <= IDLE;
        end else begin
            in_d    <= in;
            rise_q  <= rise;
            pending <= pending_nxt;

            // Re-arrival on a bit that stays pending is merged and flagged;
            // the bit being cleared by this cycle's accept does not count.
            if (|(rise_q & pending & ~clr)) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pending != 8'h00) begin
                        out       <= prio_code;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    // out stays frozen until the consumer takes it; the
                    // return to IDLE costs one bubble before the next code.
                    if (accept) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder83_evt.sv
// ---------------------------------------------------------------------------
// tb_encoder83_evt
//
// Self-checking bench for encoder83_evt. Inputs change on the falling edge,
// a behavioural model advances on the rising edge, and all DUT outputs are
// compared against the model on the next falling edge. Directed scenarios
// add constant-valued checks for latency, ordering, backpressure, collision
// and reset behaviour; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_encoder83_evt;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_v;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] m_in_d;
    logic [7:0] m_rise;
    logic [7:0] m_pend;
    logic [2:0] m_out;
    logic       m_valid;
    logic       m_ovf;

    logic [2:0] delivered[$];

    encoder83_evt dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .in        (in_v),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of model behaviour, written from the event rules: edges are
    // registered once, then merged into a pending set; an offered code is
    // the index of the highest pending bit (floor(log2(set))).
    task automatic model_edge(input logic [7:0] iv, input logic rv, input logic sv);
        logic [7:0] old_pend;
        logic [7:0] taken;
        int         top;
        if (sv) begin
            m_in_d  = 8'h00;
            m_rise  = 8'h00;
            m_pend  = 8'h00;
            m_out   = 3'd0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            old_pend = m_pend;
            taken    = (m_valid && rv) ? 8'(1 << m_out) : 8'h00;
            if ((m_rise & old_pend & ~taken) != 8'h00) m_ovf = 1'b1;
            m_pend = (old_pend & ~taken) | m_rise;
            if (!m_valid) begin
                if (old_pend != 8'h00) begin
                    top     = $clog2(int'(old_pend) + 1) - 1;
                    m_out   = 3'(top);
                    m_valid = 1'b1;
                end
            end else if (rv) begin
                m_valid = 1'b0;
            end
            m_rise = iv & ~m_in_d;
            m_in_d = iv;
        end
    endtask

    // Called at a falling edge: drive inputs, advance DUT and model one
    // clock, compare on the next falling edge.
    task automatic step(input logic [7:0] iv, input logic rv, input logic sv);
        in_v      = iv;
        out_ready = rv;
        rst       = sv;
        if (!sv && rv && out_valid) delivered.push_back(out);
        @(posedge clk);
        model_edge(iv, rv, sv);
        @(negedge clk);
        check("out",       32'(out),       32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("pending",   32'(pending),   32'(m_pend));
        check("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    int n_deliv;

    initial begin
        in_v      = 8'h00;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);

        // Reset state
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        check("rst_out",       32'(out),       32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_pending",   32'(pending),   32'h0);
        check("rst_overflow",  32'(overflow),  32'h0);

        // Single event, bit 3
        step(8'h08, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        check("single_pend", 32'(pending), 32'h08);
        check("single_nv",   32'(out_valid), 32'h0);
        step(8'h00, 1'b1, 1'b0);
        check("single_out",   32'(out),       32'h3);
        check("single_valid", 32'(out_valid), 32'h1);
        step(8'h00, 1'b1, 1'b0);
        check("single_drop",  32'(out_valid), 32'h0);
        check("single_clear", 32'(pending),   32'h00);
        step(8'h00, 1'b1, 1'b0);

        // Priority order 7, 2, 0
        delivered.delete();
        step(8'h85, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(8'h00, 1'b1, 1'b0);
        check("prio_count", 32'(delivered.size()), 32'd3);
        if (delivered.size() == 3) begin
            check("prio_0", 32'(delivered[0]), 32'd7);
            check("prio_1", 32'(delivered[1]), 32'd2);
            check("prio_2", 32'(delivered[2]), 32'd0);
        end

        // Backpressure: code 1 held, later bit 6 waits
        for (int i = 0; i < 5; i++) step(8'h02, 1'b0, 1'b0);
        step(8'h40, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0);
        check("bp_hold_out",  32'(out),       32'h1);
        check("bp_hold_v",    32'(out_valid), 32'h1);
        check("bp_pend",      32'(pending),   32'h42);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check("bp_next_out",  32'(out),       32'h6);
        check("bp_next_v",    32'(out_valid), 32'h1);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // Re-pulse while held -> overflow
        step(8'h00, 1'b0, 1'b1);
        step(8'h08, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check("ovf_set",   32'(overflow),   32'h1);
        check("ovf_pend3", 32'(pending[3]), 32'h1);

        // Re-pulse timed to the accept -> no overflow, code 3 again
        step(8'h00, 1'b0, 1'b1);
        step(8'h08, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        check("coll_pend3", 32'(pending[3]), 32'h1);
        check("coll_drop",  32'(out_valid),  32'h0);
        step(8'h00, 1'b0, 1'b0);
        check("coll_again", 32'(out),        32'h3);
        check("coll_valid", 32'(out_valid),  32'h1);
        check("coll_noovf", 32'(overflow),   32'h0);
        step(8'h00, 1'b1, 1'b0);
        check("coll_clear", 32'(pending),    32'h00);

        // Reset mid-operation, then a line held across release
        step(8'hC0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check("mid_pend",  32'(pending),   32'hC0);
        check("mid_valid", 32'(out_valid), 32'h1);
        step(8'h01, 1'b1, 1'b1);
        check("mid_rst_out",  32'(out),       32'h0);
        check("mid_rst_v",    32'(out_valid), 32'h0);
        check("mid_rst_pend", 32'(pending),   32'h00);
        check("mid_rst_ovf",  32'(overflow),  32'h0);
        delivered.delete();
        for (int i = 0; i < 8; i++) step(8'h01, 1'b1, 1'b0);
        n_deliv = delivered.size();
        check("held_count", 32'(n_deliv), 32'd1);
        if (n_deliv == 1) check("held_code", 32'(delivered[0]), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(8'($urandom & $urandom & $urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 60) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/encoder83_evt.md
ENCODER83_EVT -- requirements
Module: encoder83_evt

Interface
REQ-001 SHALL have port sys_clk  input  1  the single clock; all state updates on its rising edge.
REQ-002 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port in  input  8  raw event request lines; bit i maps to code i.
REQ-004 SHALL have port out  output  3  encoded event index, registered.
REQ-005 SHALL have port out_valid  output  1  out holds an undelivered event code.
REQ-006 SHALL have port out_ready  input  1  consumer accepts out when high with out_valid.
REQ-007 SHALL have port pending  output  8  registered set of captured, undelivered events.
REQ-008 SHALL have port overflow  output  1  sticky flag: an event was lost.
REQ-009 SHALL have parameter-free fixed widths: 8 request lines, 3-bit code.

Function
REQ-010 SHALL register in into in_d every cycle; rise[i] = in[i] & ~in_d[i].
REQ-011 SHALL set pending[i] on the clock edge after rise[i] is seen, regardless of state.
REQ-012 SHALL encode as the exact inverse of the team's 3-to-8 decoder: bit 0 -> 3'b000 ... bit 7 -> 3'b111.
REQ-013 SHALL select by fixed priority, highest index first (bit 7 highest, bit 0 lowest).
REQ-014 SHALL implement a two-state FSM: IDLE, PRESENT.
REQ-015 IDLE: if pending != 0, load out with the priority code of pending, set out_valid, go to PRESENT; else remain IDLE, out_valid = 0.
REQ-016 PRESENT: while out_valid & ~out_ready, hold out and out_valid stable; new events only update pending.
REQ-017 PRESENT: on out_valid & out_ready (accept), clear pending[out], drop out_valid, go to IDLE.
REQ-018 SHALL therefore deliver at most one code per 2 cycles (one IDLE bubble after each accept).
REQ-019 Latency: rise sampled at edge N -> pending set at edge N+1 -> out_valid high after edge N+2, when idle with pending == 0.
REQ-020 Same bit set by rise and cleared by accept in the same cycle: set wins; pending[i] stays 1.
REQ-021 Rise on a bit already pending and not cleared that cycle SHALL set overflow; the event is merged, not queued.
REQ-022 overflow SHALL stay 1 until reset.
REQ-023 out SHALL not change while out_valid is high; a higher-priority arrival waits until the next IDLE.
REQ-024 out_ready while out_valid = 0 SHALL have no effect.
REQ-025 Multiple simultaneous rises SHALL all set pending; codes are delivered in priority order.

Reset
REQ-026 sys_rst high at an edge: in_d = 0, pending = 0, out = 3'b000, out_valid = 0, overflow = 0, state = IDLE.
REQ-027 Reset SHALL override all activity mid-operation, including an in-flight accept; nothing is delivered or cleared in that cycle.
REQ-028 Because in_d resets to 0, a line held high through reset release SHALL register as one event on the first cycle after release.

Verification
REQ-029 Single event: pulse in = 8'h08 one cycle, out_ready = 1 -> out = 3'b011, out_valid high 2 edges after sampling, one cycle only; pending returns 8'h00.
REQ-030 Priority order: in = 8'h85 in one cycle, out_ready = 1 -> codes 7, 2, 0 in that order, each separated by one idle cycle.
REQ-031 Backpressure: in = 8'h02 with out_ready = 0 for 5 cycles, then a pulse on bit 6 -> out stays 3'b001 until accept; then 3'b110 is delivered.
REQ-032 Set/clear collision and overflow: re-pulse bit 3 while code 3 is held -> overflow = 1, pending[3] stays set. Re-pulse bit 3 on the exact accept cycle -> pending[3] stays set, code 3 is delivered again, and overflow is not set by that collision.
REQ-033 Reset mid-operation: assert sys_rst while out_valid = 1 and pending = 8'hC0 -> next cycle all outputs 0. With in held at 8'h01 across release -> code 3'b000 is delivered once.
